// File: rtl/gray_to_bin_monitor_if.sv
// Stream bundle for the Gray-to-binary monitor.
// Carries the input and output handshakes plus the error count.
interface gray_to_bin_monitor_if #(
  parameter int W  = 4,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_gray;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_bin;
  logic [1:0]    out_step;
  logic [CW-1:0] err_count;

  modport master (
    output in_valid,
    output in_gray,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bin,
    input  out_step,
    input  err_count
  );

  modport slave (
    input  in_valid,
    input  in_gray,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bin,
    output out_step,
    output err_count
  );
endinterface

// File: rtl/gray_to_bin_monitor.sv
// Gray-to-binary decoder with a one-entry output register.
// Classifies each step as first/up/down/illegal and counts illegal steps.
module gray_to_bin_monitor #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  gray_to_bin_monitor_if.slave bus
);

  localparam logic [1:0] ST_FIRST = 2'b00;
  localparam logic [1:0] ST_UP    = 2'b01;
  localparam logic [1:0] ST_DOWN  = 2'b10;
  localparam logic [1:0] ST_ILL   = 2'b11;

  logic [W-1:0]  bin;
  logic [W-1:0]  prev_bin;
  logic [W-1:0]  inc;
  logic [W-1:0]  dec;
  logic          have_prev;
  logic          in_ready;
  logic          acc;
  logic [1:0]    step;
  logic          out_valid_q;
  logic [W-1:0]  out_bin_q;
  logic [1:0]    out_step_q;
  logic [CW-1:0] err_q;

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(bus.in_gray >> i);
    end
  end

  assign inc = prev_bin + W'(1);
  assign dec = prev_bin - W'(1);

  always_comb begin
    step = ST_ILL;
    if (!have_prev || clr) begin
      step = ST_FIRST;
    end else if (bin == inc) begin
      step = ST_UP;
    end else if (bin == dec) begin
      step = ST_DOWN;
    end
  end

  assign in_ready = !out_valid_q || bus.out_ready;
  assign acc      = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_step_q  <= ST_FIRST;
      prev_bin    <= '0;
      have_prev   <= 1'b0;
      err_q       <= '0;
    end else begin
      if (acc) begin
        out_valid_q <= 1'b1;
        out_bin_q   <= bin;
        out_step_q  <= step;
        prev_bin    <= bin;
        have_prev   <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A word accepted alongside clr restarts tracking from itself.
      if (clr) begin
        err_q <= '0;
        if (!acc) begin
          have_prev <= 1'b0;
        end
      end else if (acc && step == ST_ILL && err_q != '1) begin
        err_q <= err_q + CW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_step  = out_step_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_gray_to_bin_monitor.sv
// Directed bench for gray_to_bin_monitor.
// A second CW=2 instance mirrors the stimulus to show saturation.
module tb_gray_to_bin_monitor;

  localparam logic [1:0] FIRST = 2'b00;
  localparam logic [1:0] UP    = 2'b01;
  localparam logic [1:0] DOWN  = 2'b10;
  localparam logic [1:0] ILL   = 2'b11;

  logic clk;
  logic rst;
  logic clr;
  int   total;
  int   passed;

  gray_to_bin_monitor_if #(.W(4), .CW(8)) bus ();
  gray_to_bin_monitor_if #(.W(4), .CW(2)) bus2 ();

  gray_to_bin_monitor #(.W(4), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus.slave)
  );

  gray_to_bin_monitor #(.W(4), .CW(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus2.slave)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_gray   = bus.in_gray;
  assign bus2.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] g,
                       input logic r, input logic c);
    bus.in_valid  = v;
    bus.in_gray   = g;
    bus.out_ready = r;
    clr           = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] g);
    drive(1'b1, g, 1'b1, 1'b0);
    tick();
  endtask

  logic [3:0] gray_tab [16];

  initial begin
    gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_bin", bus.out_bin, 0);
    chk("rst_step", bus.out_step, FIRST);
    chk("rst_err", bus.err_count, 0);
    chk("rst_ready", bus.in_ready, 1);

    for (int i = 0; i < 16; i++) begin
      send(gray_tab[i]);
      chk($sformatf("dec_valid%0d", i), bus.out_valid, 1);
      chk($sformatf("dec_bin%0d", i), bus.out_bin, i);
      chk($sformatf("dec_step%0d", i), bus.out_step,
          (i == 0) ? FIRST : UP);
    end
    chk("dec_err", bus.err_count, 0);

    send(4'b0000);
    chk("wrap_bin0", bus.out_bin, 0);
    chk("wrap_up", bus.out_step, UP);
    send(4'b1000);
    chk("wrap_bin15", bus.out_bin, 15);
    chk("wrap_down", bus.out_step, DOWN);
    send(4'b1001);
    chk("wrap_bin14", bus.out_bin, 14);
    chk("wrap_down2", bus.out_step, DOWN);
    chk("wrap_err", bus.err_count, 0);

    drive(1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    chk("clr_drain", bus.out_valid, 0);
    chk("clr_bin_hold", bus.out_bin, 14);
    send(4'b0000);
    chk("ill_first", bus.out_step, FIRST);
    send(4'b0011);
    chk("ill_bin2", bus.out_bin, 2);
    chk("ill_step1", bus.out_step, ILL);
    chk("ill_err1", bus.err_count, 1);
    send(4'b0011);
    chk("ill_step2", bus.out_step, ILL);
    chk("ill_err2", bus.err_count, 2);
    chk("ill_err2_cw2", bus2.err_count, 2);

    drive(1'b1, 4'b0110, 1'b1, 1'b1);
    tick();
    chk("col_bin4", bus.out_bin, 4);
    chk("col_first", bus.out_step, FIRST);
    chk("col_err", bus.err_count, 0);
    chk("col_err_cw2", bus2.err_count, 0);
    send(4'b0111);
    chk("col_bin5", bus.out_bin, 5);
    chk("col_up", bus.out_step, UP);

    for (int i = 0; i < 6; i++) begin
      send(4'b0111);
      if (i == 2) chk("sat_cw2_3", bus2.err_count, 3);
    end
    chk("sat_step", bus.out_step, ILL);
    chk("sat_err6", bus.err_count, 6);
    chk("sat_cw2_6", bus2.err_count, 3);

    drive(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    chk("bp_empty", bus.out_valid, 0);
    drive(1'b1, 4'b0110, 1'b0, 1'b0);
    chk("bp_ready_in", bus.in_ready, 1);
    tick();
    chk("bp_cap_valid", bus.out_valid, 1);
    chk("bp_cap_bin", bus.out_bin, 4);
    chk("bp_cap_step", bus.out_step, DOWN);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0010, 1'b0, 1'b0);
      chk($sformatf("bp_stall_rdy%0d", i), bus.in_ready, 0);
      tick();
      chk($sformatf("bp_stall_bin%0d", i), bus.out_bin, 4);
      chk($sformatf("bp_stall_vld%0d", i), bus.out_valid, 1);
    end
    drive(1'b1, 4'b0010, 1'b1, 1'b0);
    chk("bp_rel_rdy", bus.in_ready, 1);
    tick();
    chk("bp_rel_valid", bus.out_valid, 1);
    chk("bp_rel_bin", bus.out_bin, 3);
    chk("bp_rel_step", bus.out_step, DOWN);
    drive(1'b0, 4'b0010, 1'b1, 1'b0);
    tick();
    chk("bp_no_dup", bus.out_valid, 0);
    chk("bp_err", bus.err_count, 6);

    send(4'b0001);
    chk("mid_valid", bus.out_valid, 1);
    rst = 1'b1;
    drive(1'b1, 4'b0011, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_bin", bus.out_bin, 0);
    chk("mid_rst_step", bus.out_step, FIRST);
    chk("mid_rst_err", bus.err_count, 0);
    chk("mid_rst_rdy", bus.in_ready, 1);
    send(4'b0111);
    chk("mid_next_bin", bus.out_bin, 5);
    chk("mid_next_first", bus.out_step, FIRST);
    chk("mid_next_err", bus.err_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
